beat_sequencer: RTL

//  Stop/run controller and beat sequencer for the reduced machine.
//  - Counts digit periods within a beat and steps through the four beats of an instruction:
//    S1 (increment CI) -> A1 (fetch) -> S2 (decode) -> A2 (execute).
//  - Applies operator keys (run switch, single-shot key) and the decoded STOP instruction.
//  - Sits between the clock/pulse generators and the store/datapath gating.

---
 rtl/beat_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/beat_sequencer.sv
// Stop/run controller and beat sequencer.
// Steps the four beats S1/A1/S2/A2 and applies operator keys and STOP.
module beat_sequencer #(
    parameter int DIGITS_PER_BEAT = 40,
    parameter int DIGIT_BITS      = 6
) (
    input  logic                  w_CLK,
    input  logic                  w_RST,
    input  logic                  w_DIG,
    input  logic                  w_KSP,
    input  logic                  w_SS,
    input  logic                  w_STP,
    output logic [DIGIT_BITS-1:0] b_PX,
    output logic [1:0]            b_BEAT,
    output logic                  w_BEAT_END,
    output logic                  w_GATE_CI,
    output logic                  w_GATE_FETCH,
    output logic                  w_GATE_EXEC,
    output logic                  SL
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_ARMED,
        ST_RUN,
        ST_SINGLE
    } state_e;

    localparam logic [DIGIT_BITS-1:0] PX_LAST = DIGIT_BITS'(DIGITS_PER_BEAT - 1);
    localparam logic [1:0] BEAT_S1 = 2'd0;
    localparam logic [1:0] BEAT_A1 = 2'd1;
    localparam logic [1:0] BEAT_A2 = 2'd3;

    logic [DIGIT_BITS-1:0] px_q, px_d;
    state_e                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic                  ss_q;
    logic                  halt_q, halt_d;
    logic                  stp_q, stp_d;
    logic                  sl_q;
    logic                  gci_q, gfe_q, gex_q;
    logic                  ss_pulse;
    logic                  beat_end;
    logic                  stp_hit;
    logic                  active_d;

    assign beat_end   = w_DIG && (px_q == PX_LAST);
    assign ss_pulse   = w_SS && !ss_q;
    assign stp_hit    = stp_q || w_STP;
    assign active_d   = (state_d == ST_RUN) || (state_d == ST_SINGLE);

    assign b_PX         = px_q;
    assign b_BEAT       = beat_q;
    assign w_BEAT_END   = beat_end;
    assign w_GATE_CI    = gci_q;
    assign w_GATE_FETCH = gfe_q;
    assign w_GATE_EXEC  = gex_q;
    assign SL           = sl_q;

    // Digit counter: free-running on the digit strobe so refresh never stops.
    always_comb begin
        px_d = px_q;
        if (w_DIG) begin
            px_d = (px_q == PX_LAST) ? '0 : px_q + 1'b1;
        end
    end

    // Next-state logic for run/stop state, beat, halt hold and STOP capture.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        halt_d  = halt_q;
        stp_d   = stp_q;
        unique case (state_q)
            ST_STOP: begin
                beat_d = BEAT_S1;
                stp_d  = 1'b0;
                if (beat_end && !w_KSP) begin
                    halt_d = 1'b0;
                end
                if (beat_end && w_KSP && !halt_q) begin
                    state_d = ST_RUN;
                end else if (ss_pulse) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                beat_d = BEAT_S1;
                stp_d  = 1'b0;
                if (beat_end) begin
                    state_d = ST_SINGLE;
                end
            end
            ST_RUN, ST_SINGLE: begin
                if (beat_q == BEAT_A2 && w_STP) begin
                    stp_d = 1'b1;
                end
                if (beat_end) begin
                    if (beat_q == BEAT_A2) begin
                        stp_d  = 1'b0;
                        beat_d = BEAT_S1;
                        if (stp_hit) begin
                            state_d = ST_STOP;
                            halt_d  = 1'b1;
                        end else if (state_q == ST_SINGLE || !w_KSP) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_STOP;
                beat_d  = BEAT_S1;
            end
        endcase
    end

    // State registers; lamp and gates are registered from the next state.
    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            px_q    <= '0;
            state_q <= ST_STOP;
            beat_q  <= BEAT_S1;
            ss_q    <= 1'b0;
            halt_q  <= 1'b0;
            stp_q   <= 1'b0;
            sl_q    <= 1'b1;
            gci_q   <= 1'b0;
            gfe_q   <= 1'b0;
            gex_q   <= 1'b0;
        end else begin
            px_q    <= px_d;
            state_q <= state_d;
            beat_q  <= beat_d;
            ss_q    <= w_SS;
            halt_q  <= halt_d;
            stp_q   <= stp_d;
            sl_q    <= (state_d == ST_STOP) || (state_d == ST_ARMED);
            gci_q   <= active_d && (beat_d == BEAT_S1);
            gfe_q   <= active_d && (beat_d == BEAT_A1);
            gex_q   <= active_d && (beat_d == BEAT_A2);
        end
    end

endmodule
